control_led: RTL and testbench

Proximity indicator for the ultrasonic ranging path. It takes the echo pulse width measured upstream (in clock cycles) and drives a single LED output `aux`. The LED is steady on for near objects, blinking for mid-range objects, and off for far objects or when measurements have gone stale. It sits between the echo-width measurement block and the board LED pin.

---
 rtl/control_led.sv | 48 ++++
 tb/tb_control_led.sv | 139 +++++++++++++
 2 files changed

// File: rtl/control_led.sv
// control_led: proximity LED driver; steady for near, blinking for mid, off for far or stale echo widths
module control_led #(
    parameter int unsigned NEAR_TH    = 3000,
    parameter int unsigned FAR_TH     = 12000,
    parameter int unsigned BLINK_HALF = 25_000_000,
    parameter int unsigned TIMEOUT    = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] echo_duration,
    output logic        aux,
    output logic [1:0]  zone
);
    localparam logic [1:0] NONE = 2'd0;
    localparam logic [1:0] NEAR = 2'd1;
    localparam logic [1:0] MID  = 2'd2;
    localparam logic [1:0] FAR  = 2'd3;
    localparam logic [31:0] near_th = NEAR_TH;
    localparam logic [31:0] far_th  = FAR_TH;
    localparam logic [31:0] blink_last = BLINK_HALF - 1;
    localparam logic [31:0] stale_last = TIMEOUT - 1;
    logic [31:0] meas, stale_cnt, blink_cnt;
    logic        valid;
    logic [1:0]  cls;
    always_comb cls = !valid ? NONE : meas < near_th ? NEAR : meas < far_th ? MID : FAR;
    always_ff @(posedge clk) begin
        if (rst) begin
            meas      <= '0;
            valid     <= 1'b0;
            stale_cnt <= '0;
            blink_cnt <= '0;
            zone      <= NONE;
            aux       <= 1'b0;
        end else begin
            if (echo_duration != '0) begin
                meas      <= echo_duration;
                valid     <= 1'b1;
                stale_cnt <= '0;
            end else if (valid) begin
                if (stale_cnt == stale_last) valid <= 1'b0;
                else stale_cnt <= stale_cnt + 1'b1;
            end
            zone      <= cls;
            blink_cnt <= (cls == MID && zone == MID && blink_cnt != blink_last) ? blink_cnt + 1'b1 : '0;
            aux       <= cls == NEAR || (cls == MID && (zone != MID || (blink_cnt == blink_last ? ~aux : aux)));
        end
    end
endmodule

// File: tb/tb_control_led.sv
// tb_control_led: table vectors, hand sequences and random stimulus against a time-based reference model
module tb_control_led;
    localparam int unsigned NEAR_TH = 3000;
    localparam int unsigned FAR_TH  = 12000;
    localparam int unsigned BH      = 4;
    localparam int unsigned TO      = 64;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] echo_duration = '0;
    logic        aux;
    logic [1:0]  zone;
    int tests = 0;
    int fails = 0;
    control_led #(.NEAR_TH(NEAR_TH), .FAR_TH(FAR_TH), .BLINK_HALF(BH), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .echo_duration(echo_duration), .aux(aux), .zone(zone)
    );
    always #10 clk = ~clk;
    logic [31:0] m_meas = '0;
    logic        m_valid = 1'b0;
    int          m_last = 0;
    int          n = 0;
    int          mid_start = 0;
    logic [1:0]  exp_zone = '0;
    logic        exp_aux = 1'b0;
    logic [1:0]  c_m;
    int          start_m;
    always @(posedge clk) begin
        c_m = !m_valid ? 2'd0 : m_meas < NEAR_TH ? 2'd1 : m_meas < FAR_TH ? 2'd2 : 2'd3;
        start_m = (c_m == 2'd2 && exp_zone != 2'd2) ? n : mid_start;
        if (rst) begin
            exp_zone <= '0;
            exp_aux  <= 1'b0;
            m_valid  <= 1'b0;
            m_meas   <= '0;
        end else begin
            mid_start <= start_m;
            exp_zone  <= c_m;
            exp_aux   <= c_m == 2'd1 || (c_m == 2'd2 && ((n - start_m) / BH) % 2 == 0);
            if (echo_duration != 0) begin
                m_meas  <= echo_duration;
                m_valid <= 1'b1;
                m_last  <= n;
            end else if (m_valid && n - m_last >= TO) begin
                m_valid <= 1'b0;
            end
        end
        n <= n + 1;
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask
    task automatic cyc(input logic [31:0] e, input logic r = 1'b0);
        echo_duration = e;
        rst = r;
        @(posedge clk);
        @(negedge clk);
        chk("model_zone", 32'(zone), 32'(exp_zone));
        chk("model_aux", 32'(aux), 32'(exp_aux));
    endtask
    typedef struct {
        logic [31:0] echo;
        logic [1:0]  zone;
        logic        aux;
    } vec_t;
    vec_t vecs[10];
    initial begin
        vecs[0] = '{32'd5000, 2'd2, 1'b1};
        vecs[1] = '{32'd2000, 2'd1, 1'b1};
        vecs[2] = '{32'd16000, 2'd3, 1'b0};
        vecs[3] = '{32'd10000, 2'd2, 1'b1};
        vecs[4] = '{32'd2999, 2'd1, 1'b1};
        vecs[5] = '{32'd3000, 2'd2, 1'b1};
        vecs[6] = '{32'd12000, 2'd3, 1'b0};
        vecs[7] = '{32'd11999, 2'd2, 1'b1};
        vecs[8] = '{32'd1, 2'd1, 1'b1};
        vecs[9] = '{32'hFFFF_FFFF, 2'd3, 1'b0};
        @(negedge clk);
        cyc(0, 1'b1);
        chk("reset_zone", 32'(zone), 0);
        chk("reset_aux", 32'(aux), 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0);
            chk("idle_zone", 32'(zone), 0);
            chk("idle_aux", 32'(aux), 0);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(vecs[i].echo);
            cyc(0);
            chk($sformatf("vec%0d_zone", i), 32'(zone), 32'(vecs[i].zone));
            chk($sformatf("vec%0d_aux", i), 32'(aux), 32'(vecs[i].aux));
        end
        cyc(0, 1'b1);
        cyc(5000);
        cyc(0);
        chk("blink_entry", 32'(aux), 1);
        for (int i = 1; i < 12; i++) begin
            cyc(i == 5 ? 32'd6000 : 32'd0);
            chk($sformatf("blink_%0d", i), 32'(aux), 32'(((i / 4) % 2) == 0));
        end
        cyc(2000);
        for (int i = 0; i < 64; i++) cyc(0);
        chk("stale_pre_zone", 32'(zone), 1);
        cyc(0);
        chk("stale_zone", 32'(zone), 0);
        chk("stale_aux", 32'(aux), 0);
        cyc(2000);
        for (int i = 0; i < 62; i++) cyc(0);
        cyc(2000);
        for (int i = 0; i < 60; i++) cyc(0);
        chk("refresh_zone", 32'(zone), 1);
        chk("refresh_aux", 32'(aux), 1);
        cyc(5000);
        for (int i = 0; i < 5; i++) cyc(0);
        cyc(0, 1'b1);
        chk("rst_mid_zone", 32'(zone), 0);
        chk("rst_mid_aux", 32'(aux), 0);
        cyc(2000, 1'b1);
        cyc(0);
        cyc(0);
        chk("rst_over_cap", 32'(zone), 0);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] v;
            case ($urandom_range(0, 5))
                0: v = $urandom_range(1, 4000);
                1: v = $urandom_range(2990, 3010);
                2: v = $urandom_range(11990, 12010);
                3: v = $urandom;
                default: v = $urandom_range(1, 20000);
            endcase
            cyc(($urandom_range(0, 39) == 0) ? v : 32'd0, $urandom_range(0, 499) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
